hex_ascii_streamer: RTL
=======================

Name: hex_ascii_streamer

Overview:
- Upstream/downstream wrapper around the hex-to-ASCII converter.
- Accepts a binary word over a valid/ready handshake and splits it into nibbles, MSB first.
- Drives each nibble to the converter's HEX input and takes back its ASCII code.
- Emits one ASCII character per handshake, followed by CR LF, for a UART TX or debug console.

Parameters:
- WIDTH, 32, input word width; multiple of 4, minimum 4.
- NIBBLES, WIDTH/4, derived (localparam); digits emitted per word.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_DATA  input  WIDTH  word to print.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  block can accept a word.
- HEX  output  4  current nibble, to converter HEX input.
- ASCII  input  8  converter result for HEX (combinational return path).
- OUT_CHAR  output  8  character to downstream.
- OUT_VALID  output  1  OUT_CHAR valid.
- OUT_READY  input  1  downstream accepts OUT_CHAR.
- BUSY  output  1  word in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous, active-low.
- Reset values:
  - state = IDLE; shift register = 0; digit counter = 0.
  - OUT_VALID = 0, OUT_CHAR = 0x00, IN_READY = 1, BUSY = 0, HEX = 0.
- Input handshake:
  - IN_READY = 1 only in IDLE.
  - Word accepted on a cycle with IN_VALID & IN_READY: IN_DATA loads into the shift register, digit counter loads NIBBLES-1, state moves to DIGIT (or PFX0 when the feature is enabled).
- Output handshake:
  - OUT_VALID = 1 in every non-IDLE state.
  - A character transfers on a cycle with OUT_VALID & OUT_READY.
  - While OUT_VALID=1 and OUT_READY=0, OUT_CHAR and state hold stable.
- Latency and throughput:
  - First character is valid the cycle after acceptance.
  - With OUT_READY held high: one character per cycle.
  - NIBBLES+2 characters per word (NIBBLES+4 with prefix).
- HEX is always shift register bits [WIDTH-1:WIDTH-4].
- States and transitions (each transition happens on a transfer unless noted):
  - IDLE: wait for the input handshake.
  - DIGIT: OUT_CHAR = ASCII. If ASCII == 0xFF (converter invalid code), OUT_CHAR = 0x3F '?' instead. On transfer, shift the register left by 4 (zero fill). If counter == 0, go to CR; else decrement the counter.
  - CR: OUT_CHAR = 0x0D; go to LF.
  - LF: OUT_CHAR = 0x0A; go to IDLE. IN_READY rises the following cycle, so there is one idle cycle between words.
- OUT_CHAR is a combinational mux of state and ASCII; the converter path is combinational, so OUT_CHAR settles within the same cycle.
- Other rules:
  - No leading-zero suppression; all NIBBLES digits are printed.
  - IN_VALID while BUSY is ignored; the pending word is not captured, and the upstream holds it.
  - Reset asserted mid-word: the word is abandoned immediately and no further characters are emitted. After release, the next accepted word starts cleanly.
  - WIDTH=4: counter width is 1 bit, and exactly one digit is emitted.

Optional Feature:
- Macro: HEX_ASCII_STREAMER_PREFIX_EN.
- Defined:
  - Two extra states, PFX0 then PFX1, come before DIGIT.
  - PFX0 emits 0x30 '0'; PFX1 emits 0x78 'x'.
  - Accept goes to PFX0. PFX0 -> PFX1 -> DIGIT, each on a transfer.
  - The shift register does not shift during the prefix.
- Undefined: accept goes straight to DIGIT, and the PFX states and their logic are absent.

Test Plan:
- WIDTH=32, IN_DATA=0xDEADBEEF, OUT_READY=1 -> ten consecutive chars 44 45 41 44 42 45 45 46 0D 0A; IN_READY high again 1 cycle after the LF transfer.
- Same word with OUT_READY toggling 1/0 every cycle -> identical 10-char sequence; OUT_CHAR stable on every stalled cycle; no char dropped or duplicated.
- Prefix macro defined, IN_DATA=0x0000001F -> 30 78 30 30 30 30 30 30 31 46 0D 0A.
- IN_VALID held high with 0x12345678 then 0x9ABCDEF0 -> second word accepted only after the first LF; output 31..38 0D 0A 39 41 42 43 44 45 46 30 0D 0A.
- RST_N pulsed low after the third digit of 0xCAFEF00D -> OUT_VALID=0 immediately; BUSY=0; next word 0x00000000 prints eight 0x30 then 0D 0A.
- WIDTH=4, IN_DATA=0xF, converter replaced by a stub returning 0xFF -> 3F 0D 0A.

Source files
------------

// File: rtl/hex_ascii_streamer_if.sv
// ----------------------------------------------------------------------------
// hex_ascii_streamer_if
// Groups the word-in handshake, the converter side-channel (HEX out, ASCII
// back) and the character-out handshake of hex_ascii_streamer.
//   IN_DATA/IN_VALID/IN_READY    : upstream word handshake
//   HEX/ASCII                    : nibble to converter, ASCII code returned
//   OUT_CHAR/OUT_VALID/OUT_READY : downstream character handshake
//   BUSY                         : a word is in progress
// slave  : the streamer's view.
// master : the environment's view (upstream, converter and downstream).
// ----------------------------------------------------------------------------
interface hex_ascii_streamer_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic [3:0]       HEX;
    logic [7:0]       ASCII;
    logic [7:0]       OUT_CHAR;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             BUSY;

    modport slave (
        input  IN_DATA, IN_VALID, ASCII, OUT_READY,
        output IN_READY, HEX, OUT_CHAR, OUT_VALID, BUSY
    );

    modport master (
        output IN_DATA, IN_VALID, ASCII, OUT_READY,
        input  IN_READY, HEX, OUT_CHAR, OUT_VALID, BUSY
    );
endinterface

// File: rtl/hex_ascii_streamer.sv
// ----------------------------------------------------------------------------
// hex_ascii_streamer
// Accepts a WIDTH-bit word, walks its nibbles MSB first through an external
// combinational hex-to-ASCII converter and emits one character per output
// handshake, followed by CR LF.
//
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : hex_ascii_streamer_if.slave (IN_*, HEX, ASCII, OUT_*, BUSY)
//
// Optional feature: define HEX_ASCII_STREAMER_PREFIX_EN to emit a "0x"
// prefix before the digits.
//
// OUT_CHAR is a combinational mux of state and the converter's ASCII return;
// IN_READY, OUT_VALID and BUSY are registered; HEX comes straight from the
// shift register.
// ----------------------------------------------------------------------------
module hex_ascii_streamer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                CLK,
    input  logic                RST_N,
    hex_ascii_streamer_if.slave bus
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    localparam logic [7:0] CH_CR      = 8'h0D;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_QMARK   = 8'h3F;
    localparam logic [7:0] CH_INVALID = 8'hFF;
`ifdef HEX_ASCII_STREAMER_PREFIX_EN
    localparam logic [7:0] CH_ZERO    = 8'h30;
    localparam logic [7:0] CH_X       = 8'h78;
`endif

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("hex_ascii_streamer: WIDTH must be a multiple of 4, minimum 4");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIGIT = 3'd1,
        CR    = 3'd2,
        LF    = 3'd3
`ifdef HEX_ASCII_STREAMER_PREFIX_EN
        ,
        PFX0  = 3'd4,
        PFX1  = 3'd5
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               xfer;
    logic [7:0]         out_char_c;

    // State and registered handshake outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, shift/count update and character mux
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        out_char_c = 8'h00;
        xfer       = out_valid_q & bus.OUT_READY;

        unique case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
                    shift_d = bus.IN_DATA;
                    cnt_d   = CNT_LAST;
`ifdef HEX_ASCII_STREAMER_PREFIX_EN
                    state_d = PFX0;
`else
                    state_d = DIGIT;
`endif
                end
            end
`ifdef HEX_ASCII_STREAMER_PREFIX_EN
            PFX0: begin
                out_char_c = CH_ZERO;
                if (xfer) begin
                    state_d = PFX1;
                end
            end
            PFX1: begin
                out_char_c = CH_X;
                if (xfer) begin
                    state_d = DIGIT;
                end
            end
`endif
            DIGIT: begin
                // The converter flags an unmappable nibble with 0xFF
                out_char_c = (bus.ASCII == CH_INVALID) ? CH_QMARK : bus.ASCII;
                if (xfer) begin
                    shift_d = shift_q << 4;
                    if (cnt_q == '0) begin
                        state_d = CR;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            CR: begin
                out_char_c = CH_CR;
                if (xfer) begin
                    state_d = LF;
                end
            end
            LF: begin
                out_char_c = CH_LF;
                if (xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs registered from the next state so they line up with it
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.BUSY      = busy_q;
    assign bus.HEX       = shift_q[WIDTH-1 -: 4];
    assign bus.OUT_CHAR  = out_char_c;

endmodule
